tiny_rv_exec_q: RTL

- Parametrised successor to the team's 8-register, 16-bit-instruction teaching core.
- Bytes arrive over a valid/ready handshake and are packed into 16-bit instructions.
- Packed instructions are buffered in a QDEPTH-entry instruction queue and executed one per cycle from the queue head.
- New behaviour versus the existing core: XLEN-wide registers, sign-extended branch offsets using same-cycle comparison, a stalling store port with handshake, queue flush, and a debug register read port.

---
 rtl/tiny_rv_exec_q_if.sv | 22 ++
 rtl/tiny_rv_exec_q.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_rv_exec_q_if.sv
// Handshake bundle for tiny_rv_exec_q: instruction byte stream in, store port out.
interface tiny_rv_exec_q_if #(
  parameter int XLEN = 8
);
  logic [7:0]      in_byte;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] out_data;
  logic [2:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/tiny_rv_exec_q.sv
// Queued 8-register teaching core: packs byte pairs into 16-bit instructions,
// buffers them and executes one per cycle from the queue head.
module tiny_rv_exec_q #(
  parameter int XLEN   = 8,
  parameter int QDEPTH = 4,
  parameter int PC_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  tiny_rv_exec_q_if.slave           bus,
  input  logic                      i_flush,
  output logic                      o_wb_valid,
  output logic [2:0]                o_wb_idx,
  output logic [XLEN-1:0]           o_wb_data,
  output logic                      o_br_taken,
  output logic [PC_W-1:0]           o_pc,
  output logic [$clog2(QDEPTH):0]   o_q_count,
  input  logic [2:0]                i_dbg_sel,
  output logic [XLEN-1:0]           o_dbg_data
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int CW  = AW + 1;
  localparam int SHW = $clog2(XLEN);

  localparam logic [0:0] PH_LO = 1'b0;
  localparam logic [0:0] PH_HI = 1'b1;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_B = 2'b11;

  logic [0:0]      r_phase;
  logic [7:0]      r_lo;
  logic [15:0]     r_queue [QDEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_regs [8];
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic [2:0]      r_out_sel;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_push;
  logic            w_exec;
  logic            w_wr;
  logic            w_taken;
  logic [15:0]     w_instr;
  logic [1:0]      w_op;
  logic [2:0]      w_rd;
  logic [2:0]      w_rs1;
  logic [2:0]      w_rs2;
  logic [4:0]      w_imm5;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_imm;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_result;
  logic [PC_W-1:0] w_br_target;

  // A pop in the same cycle never opens a slot: readiness comes from the registered count.
  assign w_in_ready = (r_count < CW'(QDEPTH));
  assign w_accept   = bus.in_valid && w_in_ready && !i_flush;
  assign w_push     = w_accept && (r_phase == PH_HI);
  assign w_exec     = (r_count != '0) && !i_flush && !(r_out_valid && !bus.out_ready);

  assign w_instr = r_queue[r_head];
  assign w_op    = w_instr[1:0];
  assign w_rd    = w_instr[4:2];
  assign w_rs1   = w_instr[7:5];
  assign w_rs2   = w_instr[10:8];
  assign w_imm5  = w_instr[12:8];
  assign w_f3    = w_instr[15:13];

  // R0 is never written, so direct indexing already reads it as zero.
  assign w_a     = r_regs[w_rs1];
  assign w_b     = r_regs[w_rs2];
  assign w_imm   = {{(XLEN-5){1'b0}}, w_imm5};
  assign w_shamt = w_b[SHW-1:0];

  always_comb begin
    w_result = '0;
    if (w_op == OP_R) begin
      case (w_f3)
        3'b000:  w_result = w_a + w_b;
        3'b001:  w_result = w_a - w_b;
        3'b010:  w_result = w_a & w_b;
        3'b011:  w_result = w_a | w_b;
        3'b100:  w_result = w_a ^ w_b;
        3'b101:  w_result = w_a << w_shamt;
        3'b110:  w_result = w_a >> w_shamt;
        default: w_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      endcase
    end else begin
      case (w_f3)
        3'b000:  w_result = w_a + w_imm;
        3'b010:  w_result = {{(XLEN-1){1'b0}}, (w_a < w_imm)};
        3'b011:  w_result = w_a & w_imm;
        3'b100:  w_result = w_a | w_imm;
        3'b101:  w_result = w_a ^ w_imm;
        default: w_result = w_imm;
      endcase
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3[1:0])
      2'b00:   w_taken = (w_a == w_b);
      2'b01:   w_taken = (w_a != w_b);
      2'b10:   w_taken = (w_a < w_b);
      default: w_taken = (w_a >= w_b);
    endcase
  end

  assign w_wr        = w_exec && ((w_op == OP_R) || (w_op == OP_I)) && (w_rd != 3'd0);
  assign w_br_target = o_pc + {{(PC_W-5){w_imm5[4]}}, w_imm5};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_LO;
      r_lo    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_phase <= PH_LO;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        if (r_phase == PH_LO) begin
          r_lo    <= bus.in_byte;
          r_phase <= PH_HI;
        end else begin
          r_phase <= PH_LO;
        end
      end
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_exec) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_exec);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_queue[r_tail] <= {bus.in_byte, r_lo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[w_rd] <= w_result;
    end
  end

  // Completing a store and issuing the next one can share an edge; the issue wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pc        <= '0;
      o_br_taken  <= 1'b0;
      o_wb_valid  <= 1'b0;
      o_wb_idx    <= '0;
      o_wb_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_exec) begin
        if (w_op == OP_B) begin
          o_pc       <= w_taken ? w_br_target : o_pc + PC_W'(1);
          o_br_taken <= w_taken;
        end else begin
          o_pc       <= o_pc + PC_W'(1);
          o_br_taken <= 1'b0;
        end
        if (w_op == OP_S) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_b;
          r_out_sel   <= w_rd;
        end
        if (w_wr) begin
          o_wb_valid <= 1'b1;
          o_wb_idx   <= w_rd;
          o_wb_data  <= w_result;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
  assign o_q_count     = r_count;
  assign o_dbg_data    = r_regs[i_dbg_sel];

endmodule
